// File: rtl/pla_fitness_sequencer.sv
// -----------------------------------------------------------------------------
// pla_fitness_sequencer
//
// Exhaustive-evaluation controller for a golden netlist and a candidate
// netlist that share one input vector bus. Every input vector is swept,
// the masked output difference is measured, and three results are kept:
// the total mismatching-bit count (saturating), the count of mismatching
// vectors, and the lowest failing vector. The sweep can stop early once
// the bit-error count exceeds a programmable budget.
//
// Two-stage pipeline:
//   stage 0 : vec drives both circuits; their XOR under the mask is
//             captured into d_q together with the vector that produced it.
//   stage 1 : the captured difference is accumulated into the results.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, abort      begin a new evaluation / cancel the running one
//   out_mask          per-output compare enable, latched at start
//   err_limit         early-stop bit budget (0 = disabled), latched at start
//   vec               registered vector driving both circuits
//   gold_po, cand_po  combinational outputs of the two circuits
//   busy              high while sweeping or draining
//   done              one-cycle pulse when results are final
//   limit_hit         sweep ended early on the error budget
//   err_bits          mismatching-bit total, saturates at all-ones
//   err_vecs          number of vectors with at least one mismatch
//   first_fail_vec    lowest failing vector, qualified by first_fail_valid
// -----------------------------------------------------------------------------
module pla_fitness_sequencer #(
    parameter int N_IN  = 12,
    parameter int N_OUT = 10,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] out_mask,
    input  logic [CNT_W-1:0] err_limit,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] gold_po,
    input  logic [N_OUT-1:0] cand_po,
    output logic             busy,
    output logic             done,
    output logic             limit_hit,
    output logic [CNT_W-1:0] err_bits,
    output logic [N_IN:0]    err_vecs,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PC_W = $clog2(N_OUT + 1);

    state_t           state_q;
    logic [N_OUT-1:0] mask_q;
    logic [CNT_W-1:0] limit_q;
    logic [N_IN-1:0]  vec_q;
    logic [N_OUT-1:0] d_q;
    logic [N_IN-1:0]  d_vec_q;
    logic             d_v_q;
    logic [CNT_W-1:0] err_bits_q;
    logic [N_IN:0]    err_vecs_q;
    logic [N_IN-1:0]  ffv_vec_q;
    logic             ffv_valid_q;
    logic             limit_hit_q;
    logic             busy_q;
    logic             done_q;

    // Stage-1 arithmetic: popcount of the captured difference, then a
    // saturating add into the bit counter.
    logic [PC_W-1:0]  popcnt;
    logic [CNT_W:0]   bits_sum;
    logic [CNT_W-1:0] err_bits_d;
    logic             limit_trip;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            popcnt = popcnt + PC_W'(d_q[i]);
        end
    end

    assign bits_sum   = {1'b0, err_bits_q} + (CNT_W + 1)'(popcnt);
    assign err_bits_d = bits_sum[CNT_W] ? {CNT_W{1'b1}} : bits_sum[CNT_W-1:0];
    // Budget is compared against the post-update count of this edge.
    assign limit_trip = d_v_q && (limit_q != '0) && (err_bits_d > limit_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            limit_q     <= '0;
            vec_q       <= '0;
            d_q         <= '0;
            d_vec_q     <= '0;
            d_v_q       <= 1'b0;
            err_bits_q  <= '0;
            err_vecs_q  <= '0;
            ffv_vec_q   <= '0;
            ffv_valid_q <= 1'b0;
            limit_hit_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        mask_q      <= out_mask;
                        limit_q     <= err_limit;
                        vec_q       <= '0;
                        d_q         <= '0;
                        d_vec_q     <= '0;
                        d_v_q       <= 1'b0;
                        err_bits_q  <= '0;
                        err_vecs_q  <= '0;
                        ffv_vec_q   <= '0;
                        ffv_valid_q <= 1'b0;
                        limit_hit_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end

                S_RUN, S_DRAIN: begin
                    if (abort) begin
                        // Cancel: pending sample is dropped, results frozen.
                        d_v_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Stage 1: accumulate the sample captured last edge.
                        if (d_v_q) begin
                            err_bits_q <= err_bits_d;
                            if (|d_q) begin
                                err_vecs_q <= err_vecs_q + 1'b1;
                                if (!ffv_valid_q) begin
                                    ffv_vec_q   <= d_vec_q;
                                    ffv_valid_q <= 1'b1;
                                end
                            end
                        end

                        if (limit_trip) begin
                            // Early stop: the sample stage 0 would take now
                            // is discarded and vec stays where it is.
                            limit_hit_q <= 1'b1;
                            d_v_q       <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (state_q == S_RUN) begin
                            // Stage 0: capture the masked difference.
                            d_q     <= (gold_po ^ cand_po) & mask_q;
                            d_vec_q <= vec_q;
                            d_v_q   <= 1'b1;
                            if (vec_q == {N_IN{1'b1}}) begin
                                state_q <= S_DRAIN;
                            end else begin
                                vec_q <= vec_q + 1'b1;
                            end
                        end else begin
                            d_v_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign limit_hit        = limit_hit_q;
    assign err_bits         = err_bits_q;
    assign err_vecs         = err_vecs_q;
    assign first_fail_vec   = ffv_vec_q;
    assign first_fail_valid = ffv_valid_q;

endmodule
